// File: rtl/utmi_pkg.sv
// Shared definitions for the UTMI receive path: write-FSM states, per-entry tag
// layout and the default widths also used by the ULPI bridge.
package utmi_pkg;

  localparam int UTMI_DATA_W = 8;
  localparam int UTMI_ADDR_W = 4;
  localparam int UTMI_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Sideband stored next to every data entry; last marks the final byte of a packet.
  typedef struct packed {
    logic last;
  } pkt_tag_t;

endpackage

// File: rtl/utmi_pkt_ram.sv
// Packet storage: data plus tag per entry, one write port, a separate port that
// sets the last flag on commit, and a combinational read port.
module utmi_pkt_ram
  import utmi_pkg::*;
#(
  parameter int DATA_W = UTMI_DATA_W,
  parameter int ADDR_W = UTMI_ADDR_W
) (
  input  logic              ext_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_last_en,
  input  logic [ADDR_W-1:0] set_last_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    pkt_tag_t          tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  // A fresh write always starts untagged; commit tags the final byte afterwards.
  always_ff @(posedge ext_clk) begin
    if (wr_en) begin
      mem[wr_addr].data     <= wr_data;
      mem[wr_addr].tag.last <= 1'b0;
    end
    if (set_last_en) begin
      mem[set_last_addr].tag.last <= 1'b1;
    end
  end

  assign rd_data = mem[rd_addr].data;
  assign rd_last = mem[rd_addr].tag.last;

endmodule

// File: rtl/utmi_rx_pkt_fifo.sv
// Packet-aware UTMI receive buffer: bytes are written tentatively, committed when
// rxactive falls, and rolled back (and counted) on rxerror or overflow.
module utmi_rx_pkt_fifo
  import utmi_pkg::*;
#(
  parameter int DATA_W = UTMI_DATA_W,
  parameter int ADDR_W = UTMI_ADDR_W,
  parameter int CNT_W  = UTMI_CNT_W
) (
  input  logic              ext_clk,
  input  logic              ext_rst_n,
  input  logic              utmi_rxactive,
  input  logic              utmi_rxvalid,
  input  logic              utmi_rxerror,
  input  logic [DATA_W-1:0] utmi_data_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              pkt_drop,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Handshake: a byte transfers on every edge where m_valid && m_ready; m_valid
  // never depends on m_ready, and m_data/m_last hold until that transfer.

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_e       state;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_commit;
  logic [ADDR_W:0] wr_tent;
  logic [ADDR_W:0] last_ptr;

  logic            full;
  logic            accepting;
  logic            wr_en;
  logic            drop_now;
  logic            commit_now;
  logic            rd_en;
  logic [DATA_W-1:0] ram_data;
  logic            ram_last;

  // Tentative bytes occupy space, so fullness is measured from the tentative pointer.
  assign full       = (wr_tent - rd_ptr) == DEPTH_V;
  assign accepting  = (state != ST_DROP);
  assign wr_en      = accepting & utmi_rxactive & utmi_rxvalid & ~utmi_rxerror & ~full;
  assign drop_now   = accepting & utmi_rxactive & (utmi_rxerror | (utmi_rxvalid & full));
  assign commit_now = (state == ST_RECV) & ~utmi_rxactive & (wr_tent != wr_commit);
  assign last_ptr   = wr_tent - ONE_V;
  assign rd_en      = m_valid & m_ready;

  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      state     <= ST_DROP;
      rd_ptr    <= '0;
      wr_commit <= '0;
      wr_tent   <= '0;
      pkt_drop  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pkt_drop <= drop_now;
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE_V;
      end
      case (state)
        ST_IDLE, ST_RECV: begin
          if (drop_now) begin
            state   <= ST_DROP;
            wr_tent <= wr_commit;
            if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end else if (utmi_rxactive) begin
            state <= ST_RECV;
            if (wr_en) begin
              wr_tent <= wr_tent + ONE_V;
            end
          end else begin
            state <= ST_IDLE;
            if (commit_now) begin
              wr_commit <= wr_tent;
            end
          end
        end
        ST_DROP: begin
          // Leaving DROP is silent so that the post-reset exit is not counted.
          if (!utmi_rxactive) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_DROP;
      endcase
    end
  end

  utmi_pkt_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .ext_clk       (ext_clk),
    .wr_en         (wr_en),
    .wr_addr       (wr_tent[ADDR_W-1:0]),
    .wr_data       (utmi_data_in),
    .set_last_en   (commit_now),
    .set_last_addr (last_ptr[ADDR_W-1:0]),
    .rd_addr       (rd_ptr[ADDR_W-1:0]),
    .rd_data       (ram_data),
    .rd_last       (ram_last)
  );

  assign m_valid = (rd_ptr != wr_commit);
  assign m_data  = m_valid ? ram_data : '0;
  assign m_last  = m_valid & ram_last;
  assign level   = wr_commit - rd_ptr;

endmodule

// File: tb/tb_utmi_rx_pkt_fifo.sv
// Directed and randomized checks of utmi_rx_pkt_fifo (ADDR_W=2, CNT_W=2) against a
// packet-level queue model of committed and tentative bytes.
module tb_utmi_rx_pkt_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  // clock / reset
  logic ext_clk   = 1'b0;
  logic ext_rst_n = 1'b0;
  always #5 ext_clk = ~ext_clk;

  logic          utmi_rxactive = 1'b0;
  logic          utmi_rxvalid  = 1'b0;
  logic          utmi_rxerror  = 1'b0;
  logic [DW-1:0] utmi_data_in  = '0;
  logic          m_ready       = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic [AW:0]   level;
  logic          pkt_drop;
  logic [CW-1:0] drop_cnt;

  utmi_rx_pkt_fifo #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .ext_clk       (ext_clk),
    .ext_rst_n     (ext_rst_n),
    .utmi_rxactive (utmi_rxactive),
    .utmi_rxvalid  (utmi_rxvalid),
    .utmi_rxerror  (utmi_rxerror),
    .utmi_data_in  (utmi_data_in),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .level         (level),
    .pkt_drop      (pkt_drop),
    .drop_cnt      (drop_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: committed-unread entries {last,data} and the in-flight packet
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] tent_q[$];
  bit            discarding = 1'b1;
  int            m_drops    = 0;
  bit            m_pulse    = 1'b0;

  logic [DW:0]   got_q[$];
  logic [DW-1:0] pkt_q[$];
  int            pulses_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit full;
    logic lb;
    if (!ext_rst_n) begin
      exp_q.delete();
      tent_q.delete();
      discarding = 1'b1;
      m_drops    = 0;
      m_pulse    = 1'b0;
      return;
    end
    full    = (exp_q.size() + tent_q.size()) == DEPTH;
    m_pulse = 1'b0;
    if (m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (discarding) begin
      if (!utmi_rxactive) discarding = 1'b0;
    end else if (!utmi_rxactive) begin
      for (int i = 0; i < tent_q.size(); i++) begin
        lb = (i == tent_q.size() - 1);
        exp_q.push_back({lb, tent_q[i]});
      end
      tent_q.delete();
    end else if (utmi_rxerror || (utmi_rxvalid && full)) begin
      tent_q.delete();
      discarding = 1'b1;
      m_pulse    = 1'b1;
      if (m_drops < CMAX) m_drops++;
    end else if (utmi_rxvalid) begin
      tent_q.push_back(utmi_data_in);
    end
  endtask

  // driver: one clock with model update, then check every output
  task automatic tick();
    if (m_valid && m_ready) got_q.push_back({m_last, m_data});
    model_edge();
    @(posedge ext_clk);
    #1;
    if (pkt_drop) pulses_seen++;
    chk("m_valid",  32'(m_valid),  32'(exp_q.size() != 0));
    chk("m_data",   32'(m_data),   exp_q.size() != 0 ? 32'(exp_q[0][DW-1:0]) : 32'd0);
    chk("m_last",   32'(m_last),   exp_q.size() != 0 ? 32'(exp_q[0][DW]) : 32'd0);
    chk("level",    32'(level),    32'(exp_q.size()));
    chk("pkt_drop", 32'(pkt_drop), 32'(m_pulse));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic idle(input int n);
    utmi_rxactive = 1'b0;
    utmi_rxvalid  = 1'b0;
    utmi_rxerror  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send pkt_q; err_at marks the byte carrying rxerror (-1: none); lead cycles of
  // rxactive with no rxvalid precede the data; one rxactive-low cycle follows.
  task automatic send_pkt(input int err_at, input int lead);
    utmi_rxactive = 1'b1;
    utmi_rxvalid  = 1'b0;
    utmi_rxerror  = 1'b0;
    for (int i = 0; i < lead; i++) tick();
    for (int i = 0; i < pkt_q.size(); i++) begin
      utmi_rxvalid = 1'b1;
      utmi_data_in = pkt_q[i];
      utmi_rxerror = (i == err_at);
      tick();
    end
    idle(1);
  endtask

  task automatic fill_random(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(DW'($urandom));
  endtask

  int base;
  logic [DW-1:0] ref_bytes[$];

  initial begin
    // reset state
    ext_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    ext_rst_n = 1'b1;
    idle(2);

    // single packet
    m_ready = 1'b1;
    got_q.delete();
    pkt_q.delete();
    pkt_q.push_back(8'hA1); pkt_q.push_back(8'hA2); pkt_q.push_back(8'hA3);
    send_pkt(-1, 0);
    chk("single_valid_after_commit", 32'(m_valid), 32'd1);
    idle(5);
    chk("single_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("single_b0", 32'(got_q[0]), 32'h0A1);
      chk("single_b1", 32'(got_q[1]), 32'h0A2);
      chk("single_b2", 32'(got_q[2]), 32'h1A3);
    end
    chk("single_level", 32'(level), 32'd0);

    // error rollback
    m_ready = 1'b0;
    base = pulses_seen;
    pkt_q.delete(); pkt_q.push_back(8'h11);
    send_pkt(-1, 0);
    pkt_q.delete(); pkt_q.push_back(8'h22); pkt_q.push_back(8'h33); pkt_q.push_back(8'h44);
    send_pkt(2, 0);
    chk("err_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("err_pulses", 32'(pulses_seen - base), 32'd1);
    chk("err_level", 32'(level), 32'd1);
    got_q.delete();
    m_ready = 1'b1;
    idle(3);
    chk("err_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("err_b0", 32'(got_q[0]), 32'h111);

    // overflow and exact fit
    m_ready = 1'b0;
    pkt_q.delete();
    for (int i = 0; i < DEPTH; i++) pkt_q.push_back(8'hC0 + 8'(i));
    send_pkt(-1, 0);
    chk("fit_level", 32'(level), 32'd4);
    pkt_q.delete(); pkt_q.push_back(8'hD0); pkt_q.push_back(8'hD1);
    send_pkt(-1, 0);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("ovf_level", 32'(level), 32'd4);
    got_q.delete();
    m_ready = 1'b1;
    idle(6);
    chk("drain_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size() && i < DEPTH; i++)
      chk("drain_byte", 32'(got_q[i]), {23'd0, (i == DEPTH - 1), 8'hC0 + 8'(i)});

    // concurrent read and write, back-to-back full-size packets
    got_q.delete();
    ref_bytes.delete();
    m_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      fill_random(DEPTH);
      foreach (pkt_q[i]) ref_bytes.push_back(pkt_q[i]);
      send_pkt(-1, 1);
    end
    idle(6);
    chk("conc_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("conc_count", 32'(got_q.size()), 32'(2 * DEPTH));
    for (int i = 0; i < got_q.size() && i < 2 * DEPTH; i++)
      chk("conc_byte", 32'(got_q[i]), {23'd0, ((i % DEPTH) == DEPTH - 1), ref_bytes[i]});

    // reset mid-packet
    base = pulses_seen;
    utmi_rxactive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      utmi_rxvalid = 1'b1;
      utmi_data_in = 8'h50 + 8'(i);
      ext_rst_n    = (i != 2);
      tick();
    end
    ext_rst_n = 1'b1;
    idle(2);
    chk("rstmid_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rstmid_level", 32'(level), 32'd0);
    chk("rstmid_pulses", 32'(pulses_seen - base), 32'd0);
    got_q.delete();
    pkt_q.delete(); pkt_q.push_back(8'h61); pkt_q.push_back(8'h62); pkt_q.push_back(8'h63);
    send_pkt(-1, 0);
    idle(4);
    chk("rstmid_next_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) chk("rstmid_next_last", 32'(got_q[2]), 32'h163);

    // saturation and zero-length packets
    base = pulses_seen;
    for (int p = 0; p < 5; p++) begin
      fill_random(2);
      send_pkt(1, 0);
    end
    chk("sat_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("sat_pulses", 32'(pulses_seen - base), 32'd5);
    pkt_q.delete();
    send_pkt(-1, 2);
    idle(2);
    chk("zlp_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("zlp_pulses", 32'(pulses_seen - base), 32'd5);
    chk("zlp_valid", 32'(m_valid), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      utmi_rxactive = ($urandom_range(0, 7) != 0);
      utmi_rxvalid  = $urandom_range(0, 1) == 1;
      utmi_rxerror  = ($urandom_range(0, 40) == 0);
      utmi_data_in  = DW'($urandom);
      m_ready       = ($urandom_range(0, 3) != 0);
      ext_rst_n     = ($urandom_range(0, 250) != 0);
      tick();
    end
    ext_rst_n = 1'b1;
    m_ready   = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
